uart_hex_loader: RTL and testbench
==================================

# uart_hex_loader

Program-load front end between the UART receiver and the CPU instruction memory. Consumes received bytes, decodes ASCII hex digits, assembles them MSB-first into 32-bit instruction words and writes each completed word into consecutive instruction-memory locations. Optionally echoes every accepted byte back through the UART transmitter. The CPU reads the memory only after loading finishes, while the loader is held off.

## Interface
Parameters:
- DEPTH, 16, number of instruction-memory words.
- AW, 4, memory address width; DEPTH must equal 2**AW.

Ports:
- clk  in  1  single clock for the whole block.
- rst  in  1  synchronous reset, active-high.
- hold  in  1  when 1, no new bytes are accepted; driven from CPU start.
- rx_data  in  8  received byte.
- rx_valid  in  1  level; rx_data valid until cleared.
- rx_clr  out  1  one-cycle pulse; consumes the current byte.
- tx_data  out  8  echo byte.
- tx_wr  out  1  one-cycle transmit strobe.
- tx_busy  in  1  transmitter busy.
- mem_we  out  1  one-cycle write strobe.
- mem_addr  out  AW  write address.
- mem_wdata  out  32  write data.
- word_count  out  AW+1  words written since reset.
- full  out  1  word_count == DEPTH.
- overflow  out  1  sticky; a completed word was dropped because memory was full.

## Operation
- FSM states:
  - IDLE: waits for a byte.
  - PROC: decodes the latched byte.
  - WRITE: writes the completed word.
- IDLE → PROC when rx_valid && !hold, and additionally !tx_busy when echo is compiled in. On that cycle rx_clr=1 and the byte is latched.
- PROC decode of the latched byte:
  - '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66) → nibble 0-F.
  - On a nibble: word <= {word[27:0], nib}, and nib_cnt advances.
  - If nib_cnt was 7: nib_cnt wraps to 0 and the FSM goes to WRITE. Otherwise the FSM returns to IDLE.
  - CR (0x0D) or LF (0x0A): clears nib_cnt and word (partial word discarded, no write), then returns to IDLE.
  - Any other byte: ignored, no state change, returns to IDLE.
- WRITE:
  - If !full: mem_we=1, mem_addr=word_count[AW-1:0], mem_wdata=word, and word_count increments.
  - If full: no write; overflow <= 1.
  - The FSM always returns to IDLE.
- Echo: in PROC, tx_wr=1 and tx_data=latched byte, for every accepted byte regardless of its class.
- hold only gates acceptance. A byte already in PROC/WRITE completes. Partial word state is kept across hold.
- Arithmetic: nib_cnt is 3 bits and wraps 7→0. word_count saturates at DEPTH and never wraps.

## Timing
- Reset values:
  - FSM = IDLE.
  - rx_clr, tx_wr, mem_we = 0.
  - tx_data, mem_addr, mem_wdata, word, nib_cnt, word_count = 0.
  - full = 0, overflow = 0.
- Reset asserted in any state returns the FSM to IDLE on the next edge. Any pending write is abandoned.
- Accept edge T: rx_clr high during cycle T. tx_wr at T+1. mem_we at T+2 for the 8th digit. IDLE again at T+2 (no write) or T+3 (write).
- Throughput: at most one byte per 2 cycles (3 when a write occurs). rx_valid is ignored outside IDLE.
- All outputs are registered. Strobes are exactly one cycle wide.
- full updates the cycle after the final write's mem_we.

## Configuration
- HEX_LOADER_ECHO_EN defined: echo path present; acceptance also requires !tx_busy.
- HEX_LOADER_ECHO_EN undefined: tx_wr tied 0 and tx_data tied 0; tx_busy ignored.

## Structure
- Shared package:
  - ASCII constants: 0x30, 0x39, 0x41, 0x46, 0x61, 0x66, 0x0A, 0x0D.
  - FSM state enum.
  - Word width constant 32.
- Sub-module ascii_hex_decode: combinational byte → {is_hex, is_eol, nib[3:0]}. It is instantiated once in uart_hex_loader.

## Test plan
- Bytes "DEADBEEF" → one mem_we, addr 0, data 0xDEADBEEF; word_count=1; 8 tx_wr pulses echoing the same bytes.
- Bytes "0000a0b3" then "00000013" → writes 0x0000A0B3 @0 and 0x00000013 @1.
- Bytes "12", LF, "00000093" → partial discarded; single write 0x00000093 @0; 'x' inserted mid-word changes nothing.
- 17 words with DEPTH=16:
  - 16 writes to addresses 0-15.
  - full=1, and overflow=1 after the 17th word.
  - word_count stays 16.
- hold=1 with rx_valid=1 for 20 cycles → rx_clr never asserted; after hold drops, the byte is accepted next cycle. With echo enabled, tx_busy=1 likewise blocks acceptance.
- rst pulse after "ABCD" → nib_cnt cleared; subsequent "11223344" writes 0x11223344 @0.

Source files
------------

// File: rtl/uart_hex_loader_pkg.sv
// Shared definitions for the ASCII-hex program loader: character codes,
// FSM state encoding and instruction word width.
package uart_hex_loader_pkg;

  localparam int WORD_W = 32;

  localparam logic [7:0] ASCII_0      = 8'h30;
  localparam logic [7:0] ASCII_9      = 8'h39;
  localparam logic [7:0] ASCII_UPPR_A = 8'h41;
  localparam logic [7:0] ASCII_UPPR_F = 8'h46;
  localparam logic [7:0] ASCII_LOWR_A = 8'h61;
  localparam logic [7:0] ASCII_LOWR_F = 8'h66;
  localparam logic [7:0] ASCII_LF     = 8'h0A;
  localparam logic [7:0] ASCII_CR     = 8'h0D;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PROC  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

endpackage

// File: rtl/uart_hex_loader_if.sv
// Byte-stream and memory-write signals between the loader and its UART /
// instruction-memory neighbours. master = loader, slave = environment.
interface uart_hex_loader_if #(
  parameter int AW = 4
);
  import uart_hex_loader_pkg::*;

  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_clr;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_busy;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [WORD_W-1:0] mem_wdata;

  modport master (
    input  rx_data, rx_valid, tx_busy,
    output rx_clr, tx_data, tx_wr, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_busy,
    input  rx_clr, tx_data, tx_wr, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/uart_hex_loader_ascii_hex_decode.sv
// Combinational classifier: a received byte is a hex digit (with its nibble
// value), a line terminator, or neither.
module ascii_hex_decode
  import uart_hex_loader_pkg::*;
(
  input  logic [7:0] byte_in,
  output logic       is_hex,
  output logic       is_eol,
  output logic [3:0] nib
);

  logic is_digit;
  logic is_upper;
  logic is_lower;

  assign is_digit = (byte_in >= ASCII_0)      && (byte_in <= ASCII_9);
  assign is_upper = (byte_in >= ASCII_UPPR_A) && (byte_in <= ASCII_UPPR_F);
  assign is_lower = (byte_in >= ASCII_LOWR_A) && (byte_in <= ASCII_LOWR_F);

  assign is_hex = is_digit || is_upper || is_lower;
  assign is_eol = (byte_in == ASCII_LF) || (byte_in == ASCII_CR);

  // Letters 'A'/'a' have low nibble 1, so adding 9 lands on 0xA.
  assign nib = is_digit ? byte_in[3:0] : (byte_in[3:0] + 4'd9);

endmodule

// File: rtl/uart_hex_loader.sv
// ASCII-hex program loader: packs hex digits MSB-first into 32-bit words and
// writes them to consecutive memory addresses. Optional echo: HEX_LOADER_ECHO_EN.
module uart_hex_loader
  import uart_hex_loader_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  uart_hex_loader_if.master bus,
  output logic [AW:0]       word_count,
  output logic              full,
  output logic              overflow
);

  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  state_t            state_reg;
  logic [7:0]        byte_reg;
  logic [WORD_W-1:0] word_reg;
  logic [2:0]        nib_cnt_reg;
  logic              is_hex;
  logic              is_eol;
  logic [3:0]        nib;
  logic              accept_ok;
  logic              at_capacity;

  ascii_hex_decode u_decode (
    .byte_in (byte_reg),
    .is_hex  (is_hex),
    .is_eol  (is_eol),
    .nib     (nib)
  );

  assign at_capacity = (word_count == DEPTH_C);

`ifdef HEX_LOADER_ECHO_EN
  logic       tx_wr_reg;
  logic [7:0] tx_data_reg;

  assign accept_ok = !bus.tx_busy;

  // Every byte reaching PROC is echoed, whatever its class.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr_reg   <= 1'b0;
      tx_data_reg <= 8'h00;
    end else begin
      tx_wr_reg <= (state_reg == ST_PROC);
      if (state_reg == ST_PROC) begin
        tx_data_reg <= byte_reg;
      end
    end
  end

  assign bus.tx_wr   = tx_wr_reg;
  assign bus.tx_data = tx_data_reg;
`else
  logic unused_tx_busy;

  assign unused_tx_busy = bus.tx_busy;
  assign accept_ok      = 1'b1;
  assign bus.tx_wr      = 1'b0;
  assign bus.tx_data    = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      byte_reg      <= 8'h00;
      word_reg      <= '0;
      nib_cnt_reg   <= 3'd0;
      bus.rx_clr    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      word_count    <= '0;
      full          <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      bus.rx_clr <= 1'b0;
      bus.mem_we <= 1'b0;
      // Lags the final write by one cycle; the write decision uses at_capacity.
      full       <= at_capacity;

      case (state_reg)
        ST_IDLE: begin
          if (bus.rx_valid && !hold && accept_ok) begin
            bus.rx_clr <= 1'b1;
            byte_reg   <= bus.rx_data;
            state_reg  <= ST_PROC;
          end
        end

        ST_PROC: begin
          state_reg <= ST_IDLE;
          if (is_hex) begin
            word_reg    <= {word_reg[WORD_W-5:0], nib};
            nib_cnt_reg <= nib_cnt_reg + 3'd1;
            if (nib_cnt_reg == 3'd7) begin
              state_reg <= ST_WRITE;
            end
          end else if (is_eol) begin
            word_reg    <= '0;
            nib_cnt_reg <= 3'd0;
          end
        end

        ST_WRITE: begin
          state_reg <= ST_IDLE;
          if (!at_capacity) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= word_count[AW-1:0];
            bus.mem_wdata <= word_reg;
            word_count    <= word_count + 1'b1;
          end else begin
            overflow <= 1'b1;
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_hex_loader.sv
// Directed self-checking bench for uart_hex_loader (DEPTH=16, AW=4).
module tb_uart_hex_loader;

  logic       clk;
  logic       rst;
  logic       hold;
  logic [4:0] word_count;
  logic       full;
  logic       overflow;

  int total;
  int bad;
  int rx_clr_cnt;

  logic [3:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];

  uart_hex_loader_if #(.AW(4)) bus ();

  uart_hex_loader #(.DEPTH(16), .AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .hold       (hold),
    .bus        (bus),
    .word_count (word_count),
    .full       (full),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr_q.push_back(bus.mem_addr);
      wr_data_q.push_back(bus.mem_wdata);
    end
    if (bus.tx_wr) tx_q.push_back(bus.tx_data);
    if (bus.rx_clr) rx_clr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_addr_q.delete();
    wr_data_q.delete();
    tx_q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit seen;
    seen = 1'b0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.rx_clr) seen = 1'b1;
    end
    if (!seen) check("rx_accept_timeout", 32'd0, 32'd1);
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [3:0] n;
    for (int k = 7; k >= 0; k--) begin
      n = w[k*4 +: 4];
      send_byte((n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n}));
    end
  endtask

  initial begin
    string deadbeef;
    logic [31:0] w;
    total        = 0;
    bad          = 0;
    rx_clr_cnt   = 0;
    rst          = 1'b1;
    hold         = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("rst_rx_clr",  {31'd0, bus.rx_clr}, 32'd0);
    check("rst_tx_wr",   {31'd0, bus.tx_wr}, 32'd0);
    check("rst_tx_data", {24'd0, bus.tx_data}, 32'd0);
    check("rst_mem_we",  {31'd0, bus.mem_we}, 32'd0);
    check("rst_addr",    {28'd0, bus.mem_addr}, 32'd0);
    check("rst_wdata",   bus.mem_wdata, 32'd0);
    check("rst_wcount",  {27'd0, word_count}, 32'd0);
    check("rst_full",    {31'd0, full}, 32'd0);
    check("rst_ovf",     {31'd0, overflow}, 32'd0);
    rst = 1'b0;

    // DEADBEEF: one write, echoed byte-for-byte when echo is built in
    deadbeef = "DEADBEEF";
    send_str(deadbeef);
    check("t1_nwr",   wr_data_q.size(), 32'd1);
    check("t1_addr",  {28'd0, wr_addr_q[0]}, 32'd0);
    check("t1_data",  wr_data_q[0], 32'hDEADBEEF);
    check("t1_count", {27'd0, word_count}, 32'd1);
    check("t1_full",  {31'd0, full}, 32'd0);
`ifdef HEX_LOADER_ECHO_EN
    check("t1_ntx", tx_q.size(), 32'd8);
    for (int i = 0; i < 8; i++) check("t1_echo", {24'd0, tx_q[i]}, {24'd0, deadbeef[i]});
`else
    check("t1_ntx", tx_q.size(), 32'd0);
`endif

    // lowercase digits, back-to-back words
    do_reset();
    send_str("0000a0b300000013");
    check("t2_nwr",   wr_data_q.size(), 32'd2);
    check("t2_addr0", {28'd0, wr_addr_q[0]}, 32'd0);
    check("t2_data0", wr_data_q[0], 32'h0000A0B3);
    check("t2_addr1", {28'd0, wr_addr_q[1]}, 32'd1);
    check("t2_data1", wr_data_q[1], 32'h00000013);
    check("t2_count", {27'd0, word_count}, 32'd2);

    // LF / CR discard partial words; junk bytes are ignored
    do_reset();
    send_str("12");
    send_byte(8'h0A);
    send_str("7");
    send_byte(8'h0D);
    send_str("0000x0093");
    check("t3_nwr",   wr_data_q.size(), 32'd1);
    check("t3_addr",  {28'd0, wr_addr_q[0]}, 32'd0);
    check("t3_data",  wr_data_q[0], 32'h00000093);
    check("t3_count", {27'd0, word_count}, 32'd1);

    // fill memory then overflow with a 17th word
    do_reset();
    for (int i = 0; i < 16; i++) send_word(32'hA5A5_0000 ^ (i * 32'h0123_4567));
    check("t4_full16", {31'd0, full}, 32'd1);
    check("t4_ovf16",  {31'd0, overflow}, 32'd0);
    send_word(32'hCAFE_F00D);
    check("t4_nwr",   wr_data_q.size(), 32'd16);
    for (int i = 0; i < 16; i++) begin
      w = 32'hA5A5_0000 ^ (i * 32'h0123_4567);
      check("t4_addr", {28'd0, wr_addr_q[i]}, i);
      check("t4_data", wr_data_q[i], w);
    end
    check("t4_count", {27'd0, word_count}, 32'd16);
    check("t4_full",  {31'd0, full}, 32'd1);
    check("t4_ovf",   {31'd0, overflow}, 32'd1);

    // hold blocks acceptance; partial word survives hold
    do_reset();
    send_str("1234");
    hold         = 1'b1;
    bus.rx_data  = "5";
    bus.rx_valid = 1'b1;
    rx_clr_cnt   = 0;
    repeat (20) @(posedge clk);
    #1;
    check("t5_hold_nclr", rx_clr_cnt, 32'd0);
    hold = 1'b0;
    @(posedge clk);
    #1;
    check("t5_hold_accept", {31'd0, bus.rx_clr}, 32'd1);
    bus.rx_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.tx_busy  = 1'b1;
    bus.rx_data  = "6";
    bus.rx_valid = 1'b1;
`ifdef HEX_LOADER_ECHO_EN
    rx_clr_cnt = 0;
    repeat (20) @(posedge clk);
    #1;
    check("t5_busy_nclr", rx_clr_cnt, 32'd0);
    bus.tx_busy = 1'b0;
`endif
    @(posedge clk);
    #1;
    check("t5_busy_accept", {31'd0, bus.rx_clr}, 32'd1);
    bus.rx_valid = 1'b0;
    bus.tx_busy  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    send_str("78");
    check("t5_nwr",  wr_data_q.size(), 32'd1);
    check("t5_data", wr_data_q[0], 32'h12345678);

    // reset mid-word clears the partial digit count
    do_reset();
    send_str("ABCD");
    do_reset();
    check("t6_rst_count", {27'd0, word_count}, 32'd0);
    send_str("11223344");
    check("t6_nwr",   wr_data_q.size(), 32'd1);
    check("t6_addr",  {28'd0, wr_addr_q[0]}, 32'd0);
    check("t6_data",  wr_data_q[0], 32'h11223344);
    check("t6_count", {27'd0, word_count}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
